// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU/video memory arbiter.
// This file holds the state encodings and default constants that the arbiter and its bench both use.
package mem_arbiter_pkg;

  // Arbiter bus states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CADDR = 2'd1,
    ST_CDATA = 2'd2,
    ST_VID   = 2'd3
  } arbState_e;

  // Default address width shared by both requesters and the memory
  localparam int AW_DEFAULT = 20;

  // Default longest video run before a waiting CPU is let in
  localparam int VID_BURST_DEFAULT = 8;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide synchronous memory port between the CPU core and the video fetcher.
// The core is stalled through cpu_ce. Video reads take priority and stream one byte per clock.
// Optional macro ARB_FAIR_EN: when defined, a burst counter forces one CPU access after VID_BURST video cycles.
// When it is undefined, video has strict priority and the burst counter is not built.
module mem_arbiter
  import mem_arbiter_pkg::*;
`ifdef ARB_FAIR_EN
#(
  parameter int AW        = AW_DEFAULT,
  parameter int VID_BURST = VID_BURST_DEFAULT
)
`else
#(
  parameter int AW = AW_DEFAULT
)
`endif
(
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_address,
  input  logic [7:0]    cpu_out,
  input  logic          cpu_wren,
  output logic [7:0]    cpu_in,
  output logic          cpu_ce,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_address,
  output logic          vid_ack,
  output logic          vid_valid,
  output logic [7:0]    vid_data,
  output logic [AW-1:0] mem_address,
  output logic [7:0]    mem_out,
  output logic          mem_wren,
  input  logic [7:0]    mem_in
);

  arbState_e st_q, st_d;
  logic [7:0] cpuIn_q;
  logic       vidValid_q;
  logic       fairForce;

`ifdef ARB_FAIR_EN
  localparam int BW = $clog2(VID_BURST + 1);

  logic [BW-1:0] bcnt_q, bcnt_d;

  // Count consecutive video cycles, saturating; any non-video cycle clears the run
  always_comb begin
    bcnt_d    = '0;
    fairForce = 1'b0;
    if (st_q == ST_VID) begin
      bcnt_d    = (bcnt_q == BW'(VID_BURST)) ? bcnt_q : bcnt_q + 1'b1;
      fairForce = cpu_req && (bcnt_q == BW'(VID_BURST - 1));
    end
  end

  // Burst counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      bcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end
`else
  assign fairForce = 1'b0;
`endif

  // Next-state choice. Video wins ties. A CPU access is never split once its address is out.
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_CADDR: st_d = ST_CDATA;
      default: begin
        if (vid_req && !fairForce) begin
          st_d = ST_VID;
        end else if (cpu_req) begin
          st_d = ST_CADDR;
        end else begin
          st_d = ST_IDLE;
        end
      end
    endcase
  end

  // Memory mux and strobes, decoded from the current state.
  // The strobes are held off while reset is high, so an access caught by reset never writes.
  always_comb begin
    mem_address = (st_q == ST_VID) ? vid_address : cpu_address;
    mem_out     = cpu_out;
    cpu_ce      = !reset && (st_q == ST_CDATA);
    mem_wren    = cpu_ce && cpu_wren;
    vid_ack     = !reset && (st_q == ST_VID);
    cpu_in      = cpu_ce ? mem_in : cpuIn_q;
    vid_valid   = vidValid_q;
    vid_data    = mem_in;
  end

  // State, CPU read-data hold and the one-cycle-delayed video valid flag
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q       <= ST_IDLE;
      cpuIn_q    <= 8'h00;
      vidValid_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      vidValid_q <= vid_ack;
      if (cpu_ce) begin
        cpuIn_q <= mem_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter.
// It models a registered one-cycle memory and drives directed CPU and video traffic.
// A scoreboard compares the read data returned to each requester.
// Behaviour under the optional macro ARB_FAIR_EN follows from the same define.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = AW_DEFAULT;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_address = '0;
  logic [7:0]    cpu_out = 8'h00;
  logic          cpu_wren = 1'b0;
  logic [7:0]    cpu_in;
  logic          cpu_ce;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_address = '0;
  logic          vid_ack;
  logic          vid_valid;
  logic [7:0]    vid_data;
  logic [AW-1:0] mem_address;
  logic [7:0]    mem_out;
  logic          mem_wren;
  logic [7:0]    mem_in;

  logic          bdWe = 1'b0;
  logic [AW-1:0] bdAddr = '0;
  logic [7:0]    bdData = 8'h00;

  bit [7:0] memArr [0:(1<<AW)-1];
  bit       memWritten [0:(1<<AW)-1];

  logic [7:0] cpuExp [$];
  logic [7:0] vidExp [$];
  int checks = 0;
  int failures = 0;
  int wrenCount = 0;

  mem_arbiter #(.AW(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_address (cpu_address),
    .cpu_out     (cpu_out),
    .cpu_wren    (cpu_wren),
    .cpu_in      (cpu_in),
    .cpu_ce      (cpu_ce),
    .vid_req     (vid_req),
    .vid_address (vid_address),
    .vid_ack     (vid_ack),
    .vid_valid   (vid_valid),
    .vid_data    (vid_data),
    .mem_address (mem_address),
    .mem_out     (mem_out),
    .mem_wren    (mem_wren),
    .mem_in      (mem_in)
  );

  // Free-running clock
  always #5 clock = ~clock;

  // Contents of any location that has never been written
  function automatic logic [7:0] memDefault(input logic [AW-1:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ {4'h0, a[19:16]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] memRead(input logic [AW-1:0] a);
    return memWritten[a] ? memArr[a] : memDefault(a);
  endfunction

  // Registered memory with one cycle of read latency and a backdoor preload port
  always @(posedge clock) begin
    if (bdWe) begin
      memArr[bdAddr]     <= bdData;
      memWritten[bdAddr] <= 1'b1;
    end else if (mem_wren) begin
      memArr[mem_address]     <= mem_out;
      memWritten[mem_address] <= 1'b1;
    end
    mem_in <= memRead(mem_address);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic cReq, input logic [AW-1:0] cAddr, input logic [7:0] cData,
                               input logic cWr, input logic vReq, input logic [AW-1:0] vAddr);
    cpu_req     = cReq;
    cpu_address = cAddr;
    cpu_out     = cData;
    cpu_wren    = cWr;
    vid_req     = vReq;
    vid_address = vAddr;
  endtask

  // One CPU access from an idle bus, checked for latency and, for writes, the memory strobe
  task automatic cpuAccess(input logic [AW-1:0] addr, input logic [7:0] wdata, input logic wr,
                           input logic [7:0] expData, input int expLat);
    int lat;
    bit done;
    lat  = 0;
    done = 1'b0;
    applyStimulus(1'b1, addr, wdata, wr, 1'b0, '0);
    if (!wr) cpuExp.push_back(expData);
    while (!done && lat < 20) begin
      nextCycle();
      lat++;
      if (cpu_ce) begin
        done    = 1'b1;
        cpu_req = 1'b0;
        if (wr) begin
          checkOutput("wr_strobe", 32'(mem_wren), 32'd1);
          checkOutput("wr_addr", 32'(mem_address), 32'(addr));
          checkOutput("wr_data", 32'(mem_out), 32'(wdata));
        end
      end
    end
    checkOutput($sformatf("cpu_latency_%0h", addr), 32'(lat), 32'(expLat));
    nextCycle();
    cpu_wren = 1'b0;
  endtask

  // Scoreboard. Video expectations are queued at ack and CPU expectations at drive time.
  // Data is compared whenever a requester is handed its byte.
  always @(negedge clock) begin
    if (vid_valid) begin
      checkOutput("vid_pending", 32'(vidExp.size() != 0), 32'd1);
      if (vidExp.size() != 0) checkOutput("vid_data", 32'(vid_data), 32'(vidExp.pop_front()));
    end
    if (vid_ack) vidExp.push_back(memRead(vid_address));
    if (cpu_ce && !cpu_wren) begin
      checkOutput("cpu_pending", 32'(cpuExp.size() != 0), 32'd1);
      if (cpuExp.size() != 0) checkOutput("cpu_in", 32'(cpu_in), 32'(cpuExp.pop_front()));
    end
    if (mem_wren) wrenCount++;
  end

  // Guard against a hung run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence
  initial begin
    int ceCount;
    int ackCount;
    int expAckTotal;
    int expCeTotal;
    int wrenBefore;
    int period;
    bit prevAck;
    bit expAck;
    bit expCe;

    // Reset with the test pattern preloaded through the backdoor
    bdWe   = 1'b1;
    bdAddr = 20'h12345;
    bdData = 8'hA5;
    nextCycle();
    bdWe = 1'b0;
    nextCycle();
    checkOutput("rst_cpu_ce", 32'(cpu_ce), 32'd0);
    checkOutput("rst_vid_ack", 32'(vid_ack), 32'd0);
    checkOutput("rst_mem_wren", 32'(mem_wren), 32'd0);
    checkOutput("rst_vid_valid", 32'(vid_valid), 32'd0);
    checkOutput("rst_cpu_in", 32'(cpu_in), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_cpu_ce", 32'(cpu_ce), 32'd0);
    checkOutput("post_rst_vid_ack", 32'(vid_ack), 32'd0);

    // CPU read on an idle bus
    cpuAccess(20'h12345, 8'h00, 1'b0, 8'hA5, 2);

    // Sustained CPU reads give one access every two clocks
    applyStimulus(1'b1, 20'h12345, 8'h00, 1'b0, 1'b0, '0);
    for (int i = 0; i < 10; i++) cpuExp.push_back(8'hA5);
    ceCount = 0;
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      ceCount += int'(cpu_ce);
      checkOutput($sformatf("duty_ce_%0d", i), 32'(cpu_ce), 32'(i % 2 == 1));
      if (i == 19) cpu_req = 1'b0;
    end
    checkOutput("duty_total", 32'(ceCount), 32'd10);
    nextCycle();
    checkOutput("cpu_in_hold", 32'(cpu_in), 32'hA5);

    // CPU write commits once, then reads back
    wrenBefore = wrenCount;
    cpuAccess(20'h00010, 8'h3C, 1'b1, 8'h00, 2);
    checkOutput("wr_once", 32'(wrenCount - wrenBefore), 32'd1);
    cpuAccess(20'h00010, 8'h00, 1'b0, 8'h3C, 2);

    // Simultaneous requests from idle: video first, CPU stalled
    applyStimulus(1'b1, 20'h12345, 8'h00, 1'b0, 1'b1, 20'h00200);
    cpuExp.push_back(8'hA5);
    nextCycle();
    checkOutput("tie_vid_ack", 32'(vid_ack), 32'd1);
    checkOutput("tie_cpu_stall", 32'(cpu_ce), 32'd0);
    checkOutput("tie_mem_addr", 32'(mem_address), 32'h00200);
    vid_req = 1'b0;
    nextCycle();
    checkOutput("tie_vid_valid", 32'(vid_valid), 32'd1);
    checkOutput("tie_vid_data", 32'(vid_data), 32'(memDefault(20'h00200)));
    checkOutput("tie_caddr_ce", 32'(cpu_ce), 32'd0);
    nextCycle();
    checkOutput("tie_cdata_ce", 32'(cpu_ce), 32'd1);
    cpu_req = 1'b0;
    nextCycle();

    // Video arriving during the CPU address cycle waits one cycle
    applyStimulus(1'b1, 20'h12345, 8'h00, 1'b0, 1'b0, '0);
    cpuExp.push_back(8'hA5);
    nextCycle();
    checkOutput("pre_caddr_ce", 32'(cpu_ce), 32'd0);
    vid_req     = 1'b1;
    vid_address = 20'h00300;
    nextCycle();
    checkOutput("pre_cdata_ce", 32'(cpu_ce), 32'd1);
    checkOutput("pre_cdata_ack", 32'(vid_ack), 32'd0);
    cpu_req = 1'b0;
    nextCycle();
    checkOutput("pre_vid_ack", 32'(vid_ack), 32'd1);
    vid_req = 1'b0;
    nextCycle();
    checkOutput("pre_vid_valid", 32'(vid_valid), 32'd1);

    // Long video stream with the CPU waiting throughout
`ifdef ARB_FAIR_EN
    period = VID_BURST_DEFAULT + 2;
`else
    period = 0;
`endif
    expAckTotal = 0;
    expCeTotal  = 0;
    for (int i = 0; i < 30; i++) begin
      if (period == 0) begin
        expAckTotal++;
      end else begin
        if ((i % period) < VID_BURST_DEFAULT) expAckTotal++;
        if ((i % period) == period - 1) begin
          expCeTotal++;
          cpuExp.push_back(8'hA5);
        end
      end
    end
    applyStimulus(1'b1, 20'h12345, 8'h00, 1'b0, 1'b1, 20'h01000);
    prevAck  = 1'b0;
    ackCount = 0;
    ceCount  = 0;
    for (int i = 0; i < 30; i++) begin
      nextCycle();
      if (prevAck) vid_address = vid_address + 1'b1;
      expAck = (period == 0) ? 1'b1 : ((i % period) < VID_BURST_DEFAULT);
      expCe  = (period == 0) ? 1'b0 : ((i % period) == period - 1);
      checkOutput($sformatf("burst_ack_%0d", i), 32'(vid_ack), 32'(expAck));
      checkOutput($sformatf("burst_ce_%0d", i), 32'(cpu_ce), 32'(expCe));
      prevAck   = vid_ack;
      ackCount += int'(vid_ack);
      ceCount  += int'(cpu_ce);
      if (i == 29) begin
        vid_req = 1'b0;
        cpu_req = 1'b0;
      end
    end
    checkOutput("burst_ack_total", 32'(ackCount), 32'(expAckTotal));
    checkOutput("burst_ce_total", 32'(ceCount), 32'(expCeTotal));
    nextCycle();
    nextCycle();

    // Reset during a CPU write data cycle abandons the write
    wrenBefore = wrenCount;
    applyStimulus(1'b1, 20'h00400, 8'h77, 1'b1, 1'b0, '0);
    nextCycle();
    checkOutput("rstw_caddr_ce", 32'(cpu_ce), 32'd0);
    nextCycle();
    reset = 1'b1;
    #1;
    checkOutput("rstw_mem_wren", 32'(mem_wren), 32'd0);
    checkOutput("rstw_cpu_ce", 32'(cpu_ce), 32'd0);
    nextCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 20'h00400, 8'h00, 1'b0, 1'b0, '0);
    #1;
    checkOutput("rstw_after_ce", 32'(cpu_ce), 32'd0);
    checkOutput("rstw_after_wren", 32'(mem_wren), 32'd0);
    checkOutput("rstw_no_commit", 32'(wrenCount - wrenBefore), 32'd0);
    nextCycle();
    cpuAccess(20'h00400, 8'h00, 1'b0, memDefault(20'h00400), 2);

    // Reset during a video read suppresses its valid
    applyStimulus(1'b0, '0, 8'h00, 1'b0, 1'b1, 20'h00500);
    nextCycle();
    checkOutput("rstv_ack", 32'(vid_ack), 32'd1);
    reset   = 1'b1;
    vid_req = 1'b0;
    #1;
    checkOutput("rstv_ack_gated", 32'(vid_ack), 32'd0);
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("rstv_valid", 32'(vid_valid), 32'd0);
    nextCycle();

    checkOutput("cpu_queue_empty", 32'(cpuExp.size()), 32'd0);
    checkOutput("vid_queue_empty", 32'(vidExp.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
